// File: rtl/rv32_types_pkg.sv
`default_nettype none
// ============================================================================
// rv32_types : shared fetch/decode types and constants.          Rev 1.0
// ============================================================================
package rv32_types;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } imem_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } imem_rsp_t;

endpackage
`default_nettype wire

// File: rtl/rv32_fetch_fifo.sv
`default_nettype none
// ============================================================================
// rv32_fetch_fifo : instruction buffer with synchronous clear.   Rev 1.0
// ============================================================================
module rv32_fetch_fifo
  import rv32_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  fetch_entry_t             wdata_i,
  input  logic                     pop_i,
  output fetch_entry_t             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/rv32_fetch_unit.sv
`default_nettype none
// ============================================================================
// rv32_fetch_unit : PC, credit-limited imem requests, redirect flush. Rev 1.0
// ============================================================================
module rv32_fetch_unit
  import rv32_types::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int          SW      = CW + 2;
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          run_q;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic          req_fire, rsp_drop, push, pop;
  logic [SW-1:0] credit_used;
  fetch_entry_t  head, wentry;

  // Every slot already promised to an in-flight or to-be-dropped word counts.
  assign credit_used    = SW'(out_q) + SW'(fifo_cnt) + SW'(drop_q);
  assign imem_req_valid = run_q && !redirect_valid && (credit_used < SW'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign fetch_valid = !fifo_empty && !redirect_valid;
  assign fetch_instr = fetch_valid ? head.instr : NOP_INSTR;
  assign fetch_pc    = fetch_valid ? head.pc : 32'h0;
  assign pop         = fetch_valid && fetch_ready;

  assign rsp_drop = imem_rsp_valid && ((drop_q != '0) || redirect_valid);
  assign push     = imem_rsp_valid && !rsp_drop;
  assign wentry   = '{instr: imem_rsp_data, pc: rsp_pc_q};

  always_comb begin
    out_d    = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & PC_MASK;
      rsp_pc_d = redirect_pc & PC_MASK;
      drop_d   = out_d;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (push) rsp_pc_d = rsp_pc_q + 32'd4;
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      run_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      run_q    <= 1'b1;
    end
  end

  rv32_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .clr_i   (redirect_valid),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  a_rsp_has_req: assert property (@(posedge clk) disable iff (!resetn)
    imem_rsp_valid |-> (out_q != '0));

  a_push_has_slot: assert property (@(posedge clk) disable iff (!resetn)
    push |-> (!fifo_full || pop));

endmodule
`default_nettype wire

// File: tb/tb_rv32_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_rv32_fetch_unit : randomized bench with in-order memory and stream model.
// ============================================================================
module tb_rv32_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_instr, fetch_pc;

  rv32_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t memq[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, lat_min = 1, lat_max = 1;
  int n_fire = 0, n_pop = 0;
  logic [31:0] exp_req, exp_fetch, prev_addr;
  bit prev_hold;
  logic s_req_valid, s_req_fire, s_fv, s_pop, s_rsp;
  logic [31:0] s_addr, s_fpc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]};
  endfunction

  // Expected stream: consecutive word PCs, restarting at each redirect target.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit mready);
    int lat;
    redirect_valid = redir; redirect_pc = rpc; fetch_ready = rdy; imem_req_ready = mready;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = word_of(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
    #1;
    s_req_valid = imem_req_valid; s_addr = imem_req_addr;
    s_req_fire = imem_req_valid && mready; s_fv = fetch_valid;
    s_pop = fetch_valid && rdy; s_rsp = imem_rsp_valid; s_fpc = fetch_pc;
    if (prev_hold && !redir) begin
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
        miscompares++;
        $display("FAIL req_hold: valid=%b addr=%h, expected valid=1 addr=%h", imem_req_valid, imem_req_addr, prev_addr);
      end
    end
    if (imem_req_valid === 1'b1) begin
      vectors++;
      if (imem_req_addr !== exp_req) begin
        miscompares++;
        $display("FAIL req_addr: got %h, expected %h", imem_req_addr, exp_req);
      end
    end
    if (fetch_valid === 1'b1) begin
      vectors++;
      if (fetch_pc !== exp_fetch || fetch_instr !== word_of(exp_fetch)) begin
        miscompares++;
        $display("FAIL fetch_stream: pc=%h instr=%h, expected pc=%h instr=%h", fetch_pc, fetch_instr, exp_fetch, word_of(exp_fetch));
      end
    end else begin
      vectors++;
      if (fetch_instr !== NOP || fetch_pc !== 32'h0) begin
        miscompares++;
        $display("FAIL idle_outputs: instr=%h pc=%h, expected %h / 0", fetch_instr, fetch_pc, NOP);
      end
    end
    if (redir) begin
      vectors++;
      if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL redirect_gate: fetch_valid=%b req_valid=%b, expected 0/0", fetch_valid, imem_req_valid);
      end
    end
    vectors++;
    if (memq.size() > DEPTH) begin
      miscompares++;
      $display("FAIL inflight_bound: %0d in flight, limit %0d", memq.size(), DEPTH);
    end
    @(posedge clk);
    if (s_rsp) void'(memq.pop_front());
    if (s_req_fire) begin
      lat = int'($urandom_range(lat_max, lat_min));
      memq.push_back('{addr: s_addr, due: cyc + lat});
      exp_req = exp_req + 32'd4;
      n_fire++;
    end
    if (s_pop) begin
      exp_fetch = exp_fetch + 32'd4;
      n_pop++;
    end
    if (redir) begin
      exp_req = rpc & 32'hFFFF_FFFC;
      exp_fetch = exp_req;
    end
    prev_hold = s_req_valid && !mready && !redir;
    prev_addr = s_addr;
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    memq.delete();
    exp_req = RST_PC; exp_fetch = RST_PC;
    prev_hold = 1'b0; n_fire = 0; n_pop = 0;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; fetch_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || fetch_instr !== NOP || fetch_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL %s: req_valid=%b fetch_valid=%b instr=%h pc=%h, expected 0 0 %h 0",
               tag, imem_req_valid, fetch_valid, fetch_instr, fetch_pc, NOP);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset_values");
    model_reset();
    resetn = 1'b1;
  endtask

  task automatic test_basic_stream();
    int first_fire = -1, first_fv = -1, pops = 0, c;
    logic [31:0] first_addr = '0;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20 && first_fv < 0; i++) begin
      c = cyc;
      step(1'b0, '0, 1'b1, 1'b1);
      if (s_req_fire && first_fire < 0) begin first_fire = c; first_addr = s_addr; end
      if (s_fv && first_fv < 0) first_fv = c;
    end
    vectors++;
    if (first_fv < 0 || first_fv - first_fire != 2) begin
      miscompares++;
      $display("FAIL first_latency: fetch_valid %0d cycles after accept, expected 2", first_fv - first_fire);
    end
    vectors++;
    if (first_addr !== RST_PC || s_fpc !== RST_PC) begin
      miscompares++;
      $display("FAIL first_pc: req %h fetch %h, expected %h", first_addr, s_fpc, RST_PC);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (s_pop) pops++;
    end
    vectors++;
    if (pops != 12) begin
      miscompares++;
      $display("FAIL throughput: %0d pops in 12 cycles, expected 12", pops);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      vectors++;
      if (n_fire - n_pop > DEPTH) begin
        miscompares++;
        $display("FAIL credit_limit: %0d words held, limit %0d", n_fire - n_pop, DEPTH);
      end
    end
    vectors++;
    if (s_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_req_valid: got %b, expected 0", s_req_valid);
    end
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_redirect_inflight();
    bit found = 0;
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h0000_3000, 1'b1, 1'b1);
    for (int i = 0; i < 10 && memq.size() != 2; i++) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_2002, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      found = s_pop;
    end
    vectors++;
    if (!found || s_fpc !== 32'h0000_2000) begin
      miscompares++;
      $display("FAIL redirect_target: popped=%0d pc=%h, expected pc 00002000", found, s_fpc);
    end
  endtask

  task automatic test_redirect_collide();
    bit found = 0;
    lat_min = 1; lat_max = 1;
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (s_fv !== 1'b1) begin
      miscompares++;
      $display("FAIL steady_valid: fetch_valid=%b, expected 1", s_fv);
    end
    step(1'b1, 32'h0000_4000, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (s_fv !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_empty: fetch_valid=%b, expected 0", s_fv);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      found = s_pop;
    end
    vectors++;
    if (!found || s_fpc !== 32'h0000_4000) begin
      miscompares++;
      $display("FAIL collide_target: popped=%0d pc=%h, expected pc 00004000", found, s_fpc);
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] a0 = 32'hDEAD_BEEF, a1 = 32'hDEAD_BEEF;
    int n = 0;
    lat_min = 1; lat_max = 1;
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    for (int i = 0; i < 10 && n < 2; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (s_req_fire) begin
        if (n == 0) a0 = s_addr; else a1 = s_addr;
        n++;
      end
    end
    vectors++;
    if (a0 !== 32'hFFFF_FFFC || a1 !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL pc_wrap: addrs %h,%h, expected fffffffc,00000000", a0, a1);
    end
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h0000_5000, 1'b0, 1'b1);
    repeat (5) step(1'b0, '0, 1'b0, 1'b1);
    resetn = 1'b0;
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #1 check_reset_outputs("mid_reset_values");
    repeat (2) @(negedge clk);
    idle_inputs();
    model_reset();
    resetn = 1'b1;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      found = s_pop;
    end
    vectors++;
    if (!found || s_fpc !== RST_PC) begin
      miscompares++;
      $display("FAIL restart_pc: popped=%0d pc=%h, expected %h", found, s_fpc, RST_PC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      lat_min = 1; lat_max = 4;
      step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_pc_wrap();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/rv32_fetch_unit.md
Name: rv32_fetch_unit

Overview:
- Producer end of the instruction interface that the decode stage consumes.
- Holds the architectural PC and issues word-aligned requests to instruction memory over a valid/ready request channel; memory answers in order.
- Buffers returned instruction words in a small FIFO and presents them to decode with their PC over a valid/ready output.
- Handles control-flow redirects from execute: flushes buffered words and discards responses that are still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- FIFO_DEPTH, 2, instruction buffer entries and maximum requests in flight; must be a power of two, minimum 2.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  request address, bits [1:0] always 0.
- imem_rsp_valid  in  1  response word valid; in order, latency of 1 or more cycles, no backpressure.
- imem_rsp_data  in  32  returned instruction word.
- redirect_valid  in  1  taken branch or jump; single-cycle pulse.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and forced to 0.
- fetch_valid  out  1  instruction available to decode.
- fetch_ready  in  1  decode accepts this cycle; low while decode is stalled.
- fetch_instr  out  32  instruction word; 32'h0000_0013 (addi x0,x0,0) when fetch_valid is 0.
- fetch_pc  out  32  PC of fetch_instr; 0 when fetch_valid is 0.

Behaviour:
- Reset (asynchronous, resetn=0):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, fetch_valid=0, fetch_instr=NOP, fetch_pc=0.
  - Fetching starts on the first clk edge after resetn deasserts.
- Credit rule:
  - imem_req_valid = !redirect_valid && (outstanding + fifo_count + drop_cnt < FIFO_DEPTH).
  - A FIFO slot is therefore guaranteed for every accepted request.
- Request handshake:
  - imem_req_addr = pc.
  - When imem_req_valid && imem_req_ready: pc += 4 (wraps modulo 2^32) and outstanding increments.
  - Address and valid hold stable until accepted, except when a redirect arrives.
- Response path:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {rsp_data, rsp_pc} is pushed into the FIFO. rsp_pc comes from an internal counter tracking the PC of the oldest in-flight request.
  - Responses are never written without a matching request; that case is an assertion failure.
- Output:
  - fetch_valid = FIFO non-empty.
  - The head entry drives fetch_instr and fetch_pc.
  - Pop when fetch_valid && fetch_ready. Pop and push in the same cycle are both legal when the FIFO is full, since a pop frees the slot.
- Redirect (highest priority):
  - In the redirect cycle, fetch_valid and imem_req_valid are both forced to 0, so no pop and no request occur.
  - On the next edge: pc=redirect_pc&~3; FIFO cleared; drop_cnt = outstanding_next (outstanding after this cycle's response is counted).
  - A response arriving in the redirect cycle is discarded.
  - The first request to the new PC is issued the cycle after the redirect.
  - Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
- Latency: with 1-cycle memory and fetch_ready=1, the first instruction is visible 2 cycles after the request is accepted. Steady-state throughput is 1 instruction/cycle.
- Full FIFO with fetch_ready=0: no new requests; no responses are lost, by the credit rule.
- Mid-operation reset: all state returns to reset values immediately; responses arriving after reset are undefined stimulus.

Decomposition:
- Shared rv32_types package receives:
  - NOP_INSTR constant (32'h0000_0013).
  - fetch_entry_t struct {instr, pc}.
  - An imem request/response struct pair for reuse by the memory model.
- One sub-module, rv32_fetch_fifo: parameterised depth, synchronous clear, push/pop with full/empty/count outputs.
- Credit, drop and PC logic stay in rv32_fetch_unit.

Test Plan:
- Reset release, RESET_PC=0x100, 1-cycle memory returning addr-derived words, fetch_ready=1 -> addresses 0x100,0x104,0x108...; fetch_pc matches in order; one instruction/cycle after 2-cycle fill.
- fetch_ready=0 for 6 cycles -> at most FIFO_DEPTH requests outstanding plus buffered; imem_req_valid drops; no word lost or duplicated when ready returns.
- Redirect to 0x2002 with 2 responses in flight (3-cycle memory) -> both late responses dropped; next fetch_pc=0x2000; no stale PC ever reaches decode.
- Redirect in the same cycle as a response and a pop -> the response is discarded, no pop occurs, and the FIFO is empty next cycle.
- PC at 0xFFFF_FFFC -> next request address 0x0000_0000.
- Assert resetn low while the FIFO is full and requests are outstanding -> all outputs show reset values the same cycle; fetching resumes cleanly from RESET_PC.
